// File: rtl/n_bit_1_to_m_stream_demux.sv
// ============================================================================
// Module   : n_bit_1_to_m_stream_demux
// Brief    : Registered 1-to-M valid/ready demux, addressed or round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module n_bit_1_to_m_stream_demux #(
    parameter  int N  = 4,
    parameter  int M  = 4,
    localparam int SW = $clog2(M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            mode,
    input  logic [SW-1:0]   select,
    input  logic            in_valid,
    input  logic [N-1:0]    in_data,
    output logic            in_ready,
    output logic [M-1:0]    out_valid,
    output logic [M*N-1:0]  out_data,
    input  logic [M-1:0]    out_ready,
    output logic [SW-1:0]   rr_ptr,
    output logic            err
);

    logic [M-1:0]   valid_q, valid_d;
    logic [M*N-1:0] data_q,  data_d;
    logic [SW-1:0]  rr_q,    rr_d;
    logic           err_q,   err_d;

    logic [SW-1:0]  w_target;
    logic [M-1:0]   w_free;
    logic           w_tgt_ok;
    logic           w_tgt_free;
    logic           w_accept;

    assign w_target = mode ? rr_q : select;
    assign w_free   = ~valid_q | out_ready;

    // Out-of-range targets are always "free" so a bad select is consumed, never stalls.
    always_comb begin
        w_tgt_ok   = 1'b0;
        w_tgt_free = 1'b1;
        for (int k = 0; k < M; k++) begin
            if (w_target == SW'(k)) begin
                w_tgt_ok   = 1'b1;
                w_tgt_free = w_free[k];
            end
        end
    end

    assign in_ready = ~rst & enable & w_tgt_free;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < M; k++) begin
            if (w_accept && w_tgt_ok && (w_target == SW'(k))) begin
                valid_d[k]       = 1'b1;
                data_d[k*N +: N] = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k]       = 1'b0;
                data_d[k*N +: N] = '0;
            end
        end
    end

    always_comb begin
        rr_d  = rr_q;
        err_d = w_accept & ~w_tgt_ok;
        if (w_accept && mode) begin
            rr_d = (rr_q == SW'(M - 1)) ? '0 : rr_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign rr_ptr    = rr_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/n_bit_1_to_m_stream_demux.md
# n_bit_1_to_m_stream_demux

Registered, handshaked 1-to-M demultiplexer: routes an N-bit input word to one of M output channels, each with a one-entry holding register and valid/ready flow control. It generalises the team's combinational 1-to-4 enable demux in three ways: parametrised width and channel count, a registered output stage with backpressure, and a round-robin distribution mode. It sits between a single producer and M independent consumers, for example a work dispatcher feeding parallel datapath lanes.

## Interface
- N, default 4: data width in bits (≥1).
- M, default 4: number of output channels (≥2, need not be a power of two).
- SW, derived as clog2(M): select and pointer width. This is a localparam, not overridable.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new word is accepted; held words still drain.
- mode  in  1  0 = addressed (target = select); 1 = round-robin (target = rr_ptr).
- select  in  SW  target channel in addressed mode.
- in_valid  in  1  producer has a word.
- in_data  in  N  input word.
- in_ready  out  1  block accepts the word this cycle (combinational).
- out_valid  out  M  bit k is high when channel k holds a word.
- out_data  out  M*N  channel k occupies bits [k*N +: N].
- out_ready  in  M  bit k is high when consumer k takes the word.
- rr_ptr  out  SW  current round-robin target (registered).
- err  out  1  one-cycle pulse when an addressed word targets select ≥ M.

## Operation
- Target t = mode ? rr_ptr : select.
- Channel k is free when out_valid[k]==0 or out_ready[k]==1. The same-cycle drain counts, so each channel sustains one word per cycle.
- in_ready = enable & (t ≥ M ? 1 : channel t free).
- Accept = in_valid & in_ready.
  - On accept with t < M: channel t loads in_data and sets out_valid[t] on the next edge.
  - On accept with t ≥ M (addressed mode only): the word is consumed and dropped, and err pulses high the next cycle. The block never deadlocks on a bad select.
- Drain: if out_valid[k] & out_ready[k] and channel k is not reloaded in the same cycle, out_valid[k] clears and channel k's data clears to 0 on the next edge.
- Simultaneous drain and reload of the same channel: the new word replaces the old one and out_valid stays high. No bubble.
- While out_valid[k] is high, channel k's data is held stable until out_ready[k].
- Non-target channels are unaffected by the input side; they drain independently.
- rr_ptr advances only on an accept in mode 1: rr_ptr ← (rr_ptr==M-1) ? 0 : rr_ptr+1. It does not advance in mode 0, on a stall, or when enable is low.
- If the round-robin target is full, the input stalls. The pointer does not skip busy channels.
- A mode change takes effect combinationally. rr_ptr keeps its value across mode changes.
- enable low: in_ready=0, rr_ptr frozen, err=0, and draining continues normally.
- in_valid does not need to be held by this block's rules. Words are only transferred on accept.

## Timing
- Reset values (clk edge with rst=1): out_valid=0, all channel data=0, rr_ptr=0, err=0.
- rst has priority over all other inputs in that cycle. Words held at reset are discarded.
- in_ready is 0 while rst is high.
- Latency: a word accepted on edge n is visible on out_valid/out_data after edge n (1 cycle).
- in_ready depends combinationally on enable, mode, select, rr_ptr, out_valid and out_ready. There is no combinational path from in_valid or in_data to any output.
- err is registered: high for exactly the one cycle after a bad-select accept.
- Throughput: 1 word per cycle aggregate, provided the target consumer keeps out_ready high.

## Test plan
- Reset, then idle: out_valid=0, out_data=0, rr_ptr=0, in_ready=1 (enable=1, mode=0, select=0).
- Addressed mode, N=4, M=4, out_ready=4'hF: send 0xA→sel 2, 0x5→sel 0 on consecutive cycles. Required: out_valid=4'b0100 with ch2=0xA, then 4'b0001 with ch0=0x5, each one cycle after accept.
- Backpressure: out_ready[1]=0, send 0x3 then 0x7 to sel 1. First is accepted; in_ready=0 for the second. Raise out_ready[1]: 0x3 drains and 0x7 loads in the same cycle, and out_valid[1] stays high.
- Round-robin, M=3, out_ready all 1, in_valid held for 6 words 1..6: channels receive 1,2,3,1-slot-reused (4→ch0, 5→ch1, 6→ch2), and rr_ptr sequence is 0,1,2,0,1,2,0.
- M=3, mode 0, select=3, in_valid=1: in_ready=1, err pulses one cycle, no out_valid bit set, rr_ptr unchanged.
- enable=0 with ch0 full and out_ready[0]=1: in_ready=0, ch0 drains to out_valid=0, rr_ptr frozen. Then assert rst mid-stream with two channels full: all outputs return to their reset values on the next edge.
